// File: rtl/xmint_prefetch_buffer_if.sv
// rtl/xmint_prefetch_buffer_if.sv - instruction bus and decode-side stream bundle for the prefetch buffer
interface xmint_prefetch_buffer_if;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    output out_valid_o, out_rdata_o, out_addr_o, out_err_o,
    input  out_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    input  out_valid_o, out_rdata_o, out_addr_o, out_err_o,
    output out_ready_i
  );
endinterface

// File: rtl/xmint_prefetch_buffer.sv
// rtl/xmint_prefetch_buffer.sv - sequential instruction prefetch with response FIFO and branch discard
// Optional XMINT_PREFETCH_PERF_EN adds the saturating stall_cnt_o counter.
module xmint_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  xmint_prefetch_buffer_if.master bus,
  output logic        busy_o
`ifdef XMINT_PREFETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);

  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_q, fetch_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic          stale_q, stale_d;
  logic          halt_q, halt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic        mem_err  [DEPTH];

  logic        gnt_fire, pending, drop, push, pop, out_valid, issue;
  logic [31:0] target;
  logic        unused_addr_bits;

  assign target           = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_bits = ^{boot_addr_i[1:0], branch_addr_i[1:0]};
  assign out_valid        = (count_q != '0);

  always_comb begin
    gnt_fire  = req_q & bus.instr_gnt_i;
    pending   = req_q & ~bus.instr_gnt_i;
    drop      = bus.instr_rvalid_i & (discard_q != '0);
    push      = bus.instr_rvalid_i & ~drop & ~branch_i;
    pop       = out_valid & bus.out_ready_i & ~branch_i;

    outst_d = outst_q;
    if (gnt_fire && !bus.instr_rvalid_i)      outst_d = outst_q + OW'(1);
    else if (!gnt_fire && bus.instr_rvalid_i) outst_d = outst_q - OW'(1);

    // A request left pending across a branch is stale: its grant adds to discard
    // and must not advance the fetch address past the new target.
    discard_d = discard_q;
    if (branch_i)                            discard_d = outst_d;
    else if (drop && !(gnt_fire && stale_q)) discard_d = discard_q - OW'(1);
    else if (!drop && gnt_fire && stale_q)   discard_d = discard_q + OW'(1);

    stale_d = stale_q;
    if (branch_i && pending) stale_d = 1'b1;
    else if (gnt_fire)       stale_d = 1'b0;

    count_d = count_q;
    if (branch_i)         count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    wr_ptr_d = branch_i ? '0 : (push ? wr_ptr_q + PW'(1) : wr_ptr_q);
    rd_ptr_d = branch_i ? '0 : (pop  ? rd_ptr_q + PW'(1) : rd_ptr_q);

    halt_d   = branch_i ? 1'b0 : (halt_q | (push & bus.instr_err_i));
    fetch_d  = branch_i ? target
             : ((gnt_fire && !stale_q) ? fetch_q + 32'd4 : fetch_q);
    rsp_pc_d = branch_i ? target : (push ? rsp_pc_q + 32'd4 : rsp_pc_q);

    // Room is reserved for every in-flight beat, so the FIFO cannot overflow.
    issue = fetch_en_i & ~halt_d & (outst_d < MAX_O)
          & (({{(CW+1-OW){1'b0}}, outst_d} + {1'b0, count_d}) < DEPTH_S);

    req_d  = pending ? 1'b1   : issue;
    addr_d = pending ? addr_q : fetch_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q     <= 1'b0;
      addr_q    <= {boot_addr_i[31:2], 2'b00};
      fetch_q   <= {boot_addr_i[31:2], 2'b00};
      rsp_pc_q  <= {boot_addr_i[31:2], 2'b00};
      outst_q   <= '0;
      discard_q <= '0;
      stale_q   <= 1'b0;
      halt_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      req_q     <= req_d;
      addr_q    <= addr_d;
      fetch_q   <= fetch_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      stale_q   <= stale_d;
      halt_q    <= halt_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bus.instr_rdata_i;
      mem_pc[wr_ptr_q]   <= rsp_pc_q;
      mem_err[wr_ptr_q]  <= bus.instr_err_i;
    end
  end

  assign bus.instr_req_o  = req_q;
  assign bus.instr_addr_o = addr_q;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_rdata_o  = mem_data[rd_ptr_q];
  assign bus.out_addr_o   = mem_pc[rd_ptr_q];
  assign bus.out_err_o    = out_valid & mem_err[rd_ptr_q];
  assign busy_o           = req_q | (outst_q != '0);

`ifdef XMINT_PREFETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (bus.out_ready_i && !out_valid && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xmint_prefetch_buffer.sv
// tb/tb_xmint_prefetch_buffer.sv - directed self-checking bench for xmint_prefetch_buffer
module tb_xmint_prefetch_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, branch, busy;
  logic [31:0] boot_addr, branch_addr;
`ifdef XMINT_PREFETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  xmint_prefetch_buffer_if bus ();

  xmint_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fetch_en_i   (fetch_en),
    .boot_addr_i  (boot_addr),
    .branch_i     (branch),
    .branch_addr_i(branch_addr),
    .bus          (bus),
    .busy_o       (busy)
`ifdef XMINT_PREFETCH_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic        gnt_en, rsp_en;
  logic [31:0] err_addr;
  logic [31:0] rsp_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  logic        pop_err_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // One clock: drive bus inputs, log grants/pops, advance to the next falling edge.
  task automatic tick();
    logic        fire, rv;
    logic [31:0] fa;
    rv = rsp_en && !rst && (rsp_q.size() > 0);
    bus.instr_gnt_i    = gnt_en;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rv ? data_of(rsp_q[0]) : 32'h0;
    bus.instr_err_i    = rv && (rsp_q[0] == err_addr);
    fire = bus.instr_req_o && gnt_en && !rst;
    fa   = bus.instr_addr_o;
    if (bus.out_valid_o && bus.out_ready_i && !branch && !rst) begin
      pop_log.push_back(bus.out_addr_o);
      pop_err_log.push_back(bus.out_err_o);
      chk("pop_data", bus.out_rdata_o, data_of(bus.out_addr_o));
    end
    @(posedge clk);
    @(negedge clk);
    if (rv) rsp_q.delete(0);
    if (fire) begin
      rsp_q.push_back(fa);
      gnt_log.push_back(fa);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n = 0;
    fetch_en = 1'b0; bus.out_ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
    while ((busy || bus.out_valid_o) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(busy | bus.out_valid_o), 32'h0);
  endtask

  task automatic redirect(input logic [31:0] a);
    branch = 1'b1; branch_addr = a;
    tick();
    branch = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); pop_log.delete(); pop_err_log.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; fetch_en = 1'b1; boot_addr = 32'h0000_0082;
    branch = 1'b0; branch_addr = 32'h0;
    gnt_en = 1'b1; rsp_en = 1'b1; err_addr = 32'hFFFF_FFFF;
    bus.out_ready_i = 1'b1; bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i = 32'h0; bus.instr_err_i = 1'b0;
    run(2);

    chk("rst_req",   32'(bus.instr_req_o), 32'h0);
    chk("rst_addr",  bus.instr_addr_o, 32'h0000_0080);
    chk("rst_valid", 32'(bus.out_valid_o), 32'h0);
    chk("rst_err",   32'(bus.out_err_o), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
`ifdef XMINT_PREFETCH_PERF_EN
    chk("rst_stall", stall_cnt, 32'h0);
`endif

    // boot fetch sequence and first-valid latency
    rst = 1'b0;
    n = 0;
    while (!bus.out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("first_valid_lat", 32'(n), 32'd3);
    run(6);
    chk("boot_gnt0", gnt_log[0], 32'h80);
    chk("boot_gnt1", gnt_log[1], 32'h84);
    chk("boot_gnt2", gnt_log[2], 32'h88);
    chk("boot_pop0", pop_log[0], 32'h80);
    chk("boot_pop1", pop_log[1], 32'h84);
    chk("boot_pop2", pop_log[2], 32'h88);
    drain();

    // FIFO full with decode stalled: exactly DEPTH grants, then one more per pop
    redirect(32'h400);
    clear_logs();
    bus.out_ready_i = 1'b0; fetch_en = 1'b1;
    run(12);
    chk("fill_grants", 32'(gnt_log.size()), 32'd4);
    chk("fill_req",    32'(bus.instr_req_o), 32'h0);
    chk("fill_valid",  32'(bus.out_valid_o), 32'h1);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    run(8);
    chk("refill_grants", 32'(gnt_log.size()), 32'd5);
    chk("refill_addr",   gnt_log[4], 32'h410);
    chk("fill_pop0",     pop_log[0], 32'h400);
    drain();

    // branch with two requests outstanding drops both responses
    redirect(32'h500);
    clear_logs();
    rsp_en = 1'b0; fetch_en = 1'b1;
    run(5);
    chk("outst_grants", 32'(gnt_log.size()), 32'd2);
    chk("outst_busy",   32'(busy), 32'h1);
    redirect(32'h202);
    chk("br_valid_off", 32'(bus.out_valid_o), 32'h0);
    rsp_en = 1'b1;
    run(8);
    chk("br_gnt_target", gnt_log[2], 32'h200);
    chk("br_pop0",       pop_log[0], 32'h200);
    chk("br_pop1",       pop_log[1], 32'h204);
    drain();

    // branch while a request waits for grant
    redirect(32'h1000);
    clear_logs();
    gnt_en = 1'b0; fetch_en = 1'b1;
    tick();
    chk("wait_req",  32'(bus.instr_req_o), 32'h1);
    chk("wait_addr", bus.instr_addr_o, 32'h1000);
    tick();
    redirect(32'h300);
    chk("wait_req_br",  32'(bus.instr_req_o), 32'h1);
    chk("wait_addr_br", bus.instr_addr_o, 32'h1000);
    tick();
    chk("wait_addr_3", bus.instr_addr_o, 32'h1000);
    gnt_en = 1'b1;
    run(8);
    chk("wait_gnt0", gnt_log[0], 32'h1000);
    chk("wait_gnt1", gnt_log[1], 32'h300);
    chk("wait_pop0", pop_log[0], 32'h300);
    drain();

    // bus error halts fetching until a branch
    redirect(32'h80);
    clear_logs();
    err_addr = 32'h88; fetch_en = 1'b1; bus.out_ready_i = 1'b1;
    run(12);
    chk("err_grants",  32'(gnt_log.size()), 32'd4);
    chk("err_req_off", 32'(bus.instr_req_o), 32'h0);
    chk("err_pop_cnt", 32'(pop_log.size()), 32'd4);
    chk("err_pop_addr", pop_log[2], 32'h88);
    chk("err_flag",     32'(pop_err_log[2]), 32'h1);
    chk("err_flag_prev", 32'(pop_err_log[1]), 32'h0);
    redirect(32'h100);
    chk("err_resume_req",  32'(bus.instr_req_o), 32'h1);
    chk("err_resume_addr", bus.instr_addr_o, 32'h100);
    run(4);
    chk("err_resume_gnt", gnt_log[4], 32'h100);
    err_addr = 32'hFFFF_FFFF;
    drain();

`ifdef XMINT_PREFETCH_PERF_EN
    rst = 1'b1; fetch_en = 1'b0; bus.out_ready_i = 1'b1;
    rsp_q.delete();
    tick();
    rst = 1'b0;
    run(5);
    chk("stall_cnt", stall_cnt, 32'd5);
    bus.out_ready_i = 1'b0;
    redirect(32'h40);
    chk("stall_keep", stall_cnt, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
